// File: rtl/types_pkg.sv
// Shared types for the load/store sequencer: FSM states, access widths and
// funct3 legality/alignment helpers.
package types_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RMW  = 2'd2
    } mem_seq_state;

    // Encodings follow funct3 (instr[14:12]) of the load/store opcodes.
    typedef enum logic [2:0] {
        MW_B  = 3'b000,
        MW_H  = 3'b001,
        MW_W  = 3'b010,
        MW_BU = 3'b100,
        MW_HU = 3'b101
    } mem_width;

    function automatic logic funct3_legal(input logic write, input logic [2:0] funct3);
        logic ok;
        case (funct3)
            MW_B, MW_H, MW_W: ok = 1'b1;
            MW_BU, MW_HU:     ok = !write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic mis;
        case (funct3)
            MW_H, MW_HU: mis = offset[0];
            MW_W:        mis = |offset;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_extend.sv
// Combinational lane select and sign/zero extension of a little-endian
// memory word for byte, halfword and word loads.
module mem_lane_extend
    import types_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // NOTE: every output of a combinational block gets a value on every path
    // (default or full case), otherwise synthesis infers a latch.
    always_comb begin
        case (offset)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase

        // Halfwords ignore offset[0]; misaligned halves are trapped upstream.
        lane_h = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            MW_B:    data = {{24{lane_b[7]}}, lane_b};
            MW_BU:   data = {24'h0, lane_b};
            MW_H:    data = {{16{lane_h[15]}}, lane_h};
            MW_HU:   data = {16'h0, lane_h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// Load/store sequencer between decode and a synchronous-read word memory.
// Optional MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into err.
module mem_access_seq
    import types_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic [31:0]           rdata,
    output logic                  resp_valid,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    mem_seq_state state;
    mem_seq_state state_next;

    logic [1:0]            off_q;
    logic [2:0]            f3_q;
    logic [15:0]           wdata_q;
    logic [ADDR_WIDTH-3:0] waddr_q;
    logic [31:0]           rdata_q;

    logic                  capture;
    logic                  misalign_trap;
    logic [31:0]           ext_data;
    logic [31:0]           merged;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign word_addr = {addr[ADDR_WIDTH-1:2], 2'b00};

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_trap = misaligned(funct3, addr[1:0]);
`else
    assign misalign_trap = 1'b0;
`endif

    mem_lane_extend u_lane_extend (
        .word   (mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (ext_data)
    );

    // Read-modify-write merge of the stored byte/half into the fetched word.
    always_comb begin
        merged = mem_rdata;
        if (f3_q == MW_B) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (off_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            off_q   <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                off_q   <= addr[1:0];
                f3_q    <= funct3;
                wdata_q <= wdata[15:0];
                waddr_q <= addr[ADDR_WIDTH-1:2];
            end
            if (state == LOAD) begin
                rdata_q <= ext_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        stall      = 1'b0;
        rdata      = rdata_q;
        resp_valid = 1'b0;
        err        = 1'b0;
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        // NOTE: reset is synchronous, so outputs are also gated by rst_n to
        // keep strobes quiet during the reset cycle itself.
        if (!rst_n) begin
            state_next = IDLE;
            rdata      = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!funct3_legal(req_write, funct3) || misalign_trap) begin
                            err = 1'b1;
                        end else if (!req_write) begin
                            mem_re     = 1'b1;
                            mem_addr   = word_addr;
                            stall      = 1'b1;
                            capture    = 1'b1;
                            state_next = LOAD;
                        end else if (funct3 == MW_W) begin
                            mem_we    = 1'b1;
                            mem_addr  = word_addr;
                            mem_wdata = wdata;
                        end else begin
                            mem_re     = 1'b1;
                            mem_addr   = word_addr;
                            stall      = 1'b1;
                            capture    = 1'b1;
                            state_next = RMW;
                        end
                    end
                end
                LOAD: begin
                    rdata      = ext_data;
                    resp_valid = 1'b1;
                    state_next = IDLE;
                end
                RMW: begin
                    mem_we     = 1'b1;
                    mem_addr   = {waddr_q, 2'b00};
                    mem_wdata  = merged;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Sequencing controller between the core's decoded load/store control and the word-wide, synchronous-read data memory. Handles byte, halfword and word loads (signed and unsigned) and stores. Sub-word stores are performed as a read-modify-write on the containing word. Holds the core via a stall output while a multi-cycle access is in flight.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width of `addr` and `mem_addr`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  load or store requested by decode (MemWrite/ResultSrc path).
- `req_write`  in  1  1 = store, 0 = load.
- `funct3`  in  3  access width and signedness (instr[14:12]).
- `addr`  in  ADDR_WIDTH  byte address from the ALU result.
- `wdata`  in  32  store data (RD2).
- `stall`  out  1  freeze PC and register-file write while high.
- `rdata`  out  32  extended load result; valid when `resp_valid` is high.
- `resp_valid`  out  1  one-cycle pulse in the final cycle of a load.
- `err`  out  1  one-cycle pulse on an illegal funct3, or a misaligned access (see Configuration).
- `mem_addr`  out  ADDR_WIDTH  word-aligned address (low 2 bits always 0).
- `mem_re`  out  1  memory read strobe; data returns on `mem_rdata` the next cycle.
- `mem_we`  out  1  memory full-word write strobe.
- `mem_wdata`  out  32  full-word write data.
- `mem_rdata`  in  32  memory read data, one cycle after `mem_re`.

## Operation
- **FSM states:** IDLE, LOAD, RMW.
- **IDLE, load:**
  - Drive `mem_re=1` and `mem_addr={addr[ADDR_WIDTH-1:2],2'b00}` combinationally, with `stall=1`.
  - Register the request's offset `addr[1:0]`, `funct3` and `wdata`; go to LOAD.
- **IDLE, store word (funct3 010):**
  - Drive `mem_we=1` and `mem_wdata=wdata` combinationally, with `stall=0`.
  - Stay in IDLE (single cycle).
- **IDLE, store byte or half (000, 001):**
  - Drive `mem_re=1` with `stall=1`; go to RMW.
- **LOAD:**
  - Select the lane of `mem_rdata` addressed by the registered offset.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU. LW passes the word through.
  - Drive `rdata` and `resp_valid=1` with `stall=0`; go to IDLE.
- **RMW:**
  - Merge the low byte or half of the registered `wdata` into `mem_rdata` at the registered offset.
  - Drive `mem_we=1` with the merged word, to the same word address, with `stall=0`; go to IDLE.
- **Request acceptance:** `req_valid` is sampled only in IDLE. The core holds the request high through the stall; it is not re-accepted in LOAD or RMW.
- **Legal funct3:**
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other value: no memory strobe, `err` pulses, stay in IDLE, `stall=0`.
- **Lane rules:**
  - Byte lane = offset[1:0].
  - Half lane = offset[1] (bytes 1:0 or 3:2).
  - Little-endian.
- **Outputs not listed for a state are 0.** `rdata` holds its last value outside LOAD.

## Timing
- **Latency:**
  - Load: 2 cycles (request cycle T, result at T+1).
  - Store word: 1 cycle.
  - Store sub-word: 2 cycles (read at T, write at T+1).
- **Stall:** high in every cycle of an access except its last. It is never high for two consecutive cycles.
- **Reset:**
  - While `rst_n=0`: state goes to IDLE, `rdata=0`, and `stall`, `resp_valid`, `err`, `mem_re`, `mem_we` are all 0. `mem_addr=0`, `mem_wdata=0`.
  - Reset asserted in LOAD or RMW aborts the access. The pending write of an RMW is never issued.
- **Address wrap:** `addr=0xFFFFFFFF` with LB reads word 0xFFFFFFFC, lane 3. No wrap beyond the word.
- **Back-to-back:** a new request is accepted in the cycle after LOAD/RMW returns to IDLE.

## Configuration
- **`MEM_MISALIGN_TRAP_EN` defined:** halfword with `addr[0]=1`, or word with `addr[1:0]!=0`:
  - No memory strobe, `err` pulses, stay in IDLE, `stall=0`.
- **Not defined:** misaligned low bits are ignored. Half uses `addr[1]`; word uses offset 0. `err` is driven only for illegal funct3.

## Structure
- **`types_pkg` additions:**
  - `mem_seq_state` enum (IDLE, LOAD, RMW).
  - `mem_width` enum on funct3: MW_B=000, MW_H=001, MW_W=010, MW_BU=100, MW_HU=101.
- **Sub-module `mem_lane_extend`:** combinational lane select and sign/zero extend, shared with any future cache path. The merge logic stays inline.

## Test plan
- Memory word 0x8000 = 0x80FF7F01. LB at addr 0x8003 -> `stall` high 1 cycle, then `resp_valid`, `rdata=0xFFFFFF80`. LBU at 0x8003 -> `rdata=0x00000080`.
- Same word. LH at 0x8002 -> `rdata=0xFFFF80FF`. LHU -> `rdata=0x000080FF`. LW at 0x8000 -> `rdata=0x80FF7F01`.
- Word 0x11223344. SB `wdata=0xAB` at 0x8001 -> cycle T `mem_re=1`, T+1 `mem_we=1`, `mem_wdata=0x1122AB44`, `stall` high only at T.
- SW `wdata=0xDEADBEEF` at 0x8004 -> same-cycle `mem_we=1`, `stall=0`. SH `0xCAFE` at 0x8006 -> memory becomes 0xCAFEBEEF.
- Assert `rst_n=0` in the RMW cycle of an SB -> no `mem_we`, memory unchanged, state IDLE, all outputs 0 next cycle.
- Load funct3 = 011 -> `err` pulse, no strobes. LW at 0x8002 -> with `MEM_MISALIGN_TRAP_EN`, `err` and no read; without it, reads word 0x8000.
